// File: rtl/fifo_ctrl_4port.sv
// Circular-FIFO pointer/flag controller driving the write port and read select of a 32x8 4-port RAM.
// Write drives are combinational, r_valid follows an accepted pop by one cycle, and pushes are refused while full.
module fifo_ctrl_4port #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int AF_LEVEL   = 28,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd,
   input  logic                  i_clr_err,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_w_s,
   output logic [DATA_WIDTH-1:0] o_w_d,
   output logic [ADDR_WIDTH-1:0] o_r_s1,
   output logic                  o_r_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);
   localparam int                PW     = ADDR_WIDTH + 1;
   localparam logic [PW-1:0]     AF_LVL = PW'(AF_LEVEL);
   localparam logic [PW-1:0]     AE_LVL = PW'(AE_LEVEL);

   logic [PW-1:0] r_wptr, r_rptr;
   logic          r_valid, r_ovf, r_udf;
   logic [PW-1:0] w_count;
   logic          w_full, w_empty, w_push, w_pop;

   // The extra wrap bit distinguishes full from empty when the low bits match.
   assign w_count = r_wptr - r_rptr;
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]) &&
                    (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);
   assign w_push  = i_wr & ~w_full;
   assign w_pop   = i_rd & ~w_empty;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_valid <= w_pop;
         // A new error in the same cycle as clr_err keeps the flag set.
         if (i_wr && w_full)  r_ovf <= 1'b1;
         else if (i_clr_err)  r_ovf <= 1'b0;
         if (i_rd && w_empty) r_udf <= 1'b1;
         else if (i_clr_err)  r_udf <= 1'b0;
      end
   end

   assign o_wr_en        = w_push;
   assign o_w_s          = r_wptr[ADDR_WIDTH-1:0];
   assign o_w_d          = i_wr_data;
   assign o_r_s1         = r_rptr[ADDR_WIDTH-1:0];
   assign o_r_valid      = r_valid;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (w_count >= AF_LVL);
   assign o_almost_empty = (w_count <= AE_LVL);
   assign o_count        = w_count;
   assign o_overflow     = r_ovf;
   assign o_underflow    = r_udf;
endmodule
